program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the word-address width of the target memory (capacity 2^ADDR_WIDTH words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, giving the byte address of the first loaded word.
REQ-003 The block SHALL be clocked by port clk, input, width 1, with all state updated on its rising edge.
REQ-004 The block SHALL be reset through port rst, input, width 1, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, width 1: a one-cycle pulse that begins a load.
REQ-006 The block SHALL have port byteIn, input, width 8: the stream data byte.
REQ-007 The block SHALL have port byteValid, input, width 1: byteIn is valid.
REQ-008 The block SHALL have port byteReady, output, width 1: the loader accepts byteIn.
REQ-009 The block SHALL have port memAddress, output, width 32: the word-aligned byte address of the memory write.
REQ-010 The block SHALL have port memWriteEnable, output, width 1: the memory write strobe.
REQ-011 The block SHALL have port memWriteData, output, width 32: the memory write data.
REQ-012 The block SHALL have port cpuRst, output, width 1: active-high hold of the downstream CPU.
REQ-013 The block SHALL have ports done and error, output, width 1 each: the terminal status flags.

Function
REQ-014 A byte SHALL transfer only in a cycle where byteValid and byteReady are both high.
REQ-015 The stream format SHALL be a 4-byte little-endian word count N followed by N data words of 4 bytes each, little-endian.
REQ-016 The FSM SHALL have states IDLE, HEADER, DATA, WRITE, CHECK, DONE and ERROR.
REQ-017 In IDLE, DONE and ERROR, a start pulse SHALL move the FSM to HEADER, clear done and error, reset the word index to 0 and assert cpuRst.
REQ-018 start SHALL be ignored in HEADER, DATA, WRITE and CHECK.
REQ-019 byteReady SHALL be high only in HEADER, DATA and CHECK.
REQ-020 After the 4th header byte, the FSM SHALL go to:
- DONE if N=0;
- ERROR if N>2^ADDR_WIDTH;
- DATA otherwise.
REQ-021 After the 4th byte of each data word, the FSM SHALL enter WRITE for exactly one cycle with:
- memWriteEnable=1;
- memWriteData equal to the assembled word;
- memAddress = BASE_ADDR + 4*index.
REQ-022 On leaving WRITE, the index SHALL increment, and the FSM SHALL return to DATA if index<N, else go to CHECK (checksum enabled) or DONE.
REQ-023 memWriteEnable SHALL be 0 in every state except WRITE.
REQ-024 memAddress and memWriteData SHALL hold their last values outside WRITE.
REQ-025 cpuRst SHALL be 1 in every state except DONE, so the CPU starts fetching at its reset PC on the first cycle after DONE is entered.
REQ-026 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERROR.
REQ-027 Idle cycles with byteValid low SHALL stall the FSM without losing any partially assembled bytes.

Reset
REQ-028 While rst=0, the block SHALL hold state IDLE, index 0, byte counter 0, byteReady=0, memWriteEnable=0, memAddress=0, memWriteData=0, cpuRst=1, done=0 and error=0.
REQ-029 A reset asserted mid-load SHALL abandon the load, with no further memory writes and no partial word written.

Configuration
REQ-030 With PROGRAM_LOADER_CHECKSUM_EN defined, a running XOR of all data words SHALL be kept, and CHECK SHALL accept 4 bytes (a little-endian checksum word), going to DONE on match and to ERROR on mismatch.
REQ-031 Without PROGRAM_LOADER_CHECKSUM_EN, the CHECK state and the XOR register SHALL not exist, and the FSM SHALL go straight from the last WRITE to DONE.
REQ-032 With PROGRAM_LOADER_CHECKSUM_EN defined and N=0, CHECK SHALL still be entered and SHALL expect checksum 32'h0.

Structure
REQ-033 The state encodings, the header length constant (4) and the word byte count constant (4) SHALL live in a shared package.
REQ-034 Byte-to-word assembly (shift register plus 2-bit byte counter with a word-complete pulse) SHALL be a sub-module named ByteAssembler32b, reused for header, data and checksum.

Verification
REQ-035 The bench SHALL cover: reset, start, stream {02,00,00,00, 78,56,34,12, EF,BE,AD,DE} -> writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, then done=1 and cpuRst=0.
REQ-036 The bench SHALL cover: header N=0 -> no memWriteEnable, and DONE reached one cycle after the 4th header byte.
REQ-037 The bench SHALL cover: ADDR_WIDTH=2 with N=5 -> error=1, cpuRst=1, no writes, and a subsequent start re-enters HEADER.
REQ-038 The bench SHALL cover: byteValid toggled randomly at 50% -> identical write sequence, and byteReady=0 in every WRITE cycle.
REQ-039 The bench SHALL cover: rst pulled low after the 6th byte -> all outputs at reset values, and no write for the partial word.
REQ-040 The bench SHALL cover, with PROGRAM_LOADER_CHECKSUM_EN: the REQ-035 stream plus checksum 0xCC99E897 -> done=1, and checksum 0x00000000 -> error=1.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader: FSM state encoding, stream
//   framing constants and the per-state status flag decode.
//   Used by program_loader and ByteAssembler32b.
//   No ports (package).
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loaderState_t;

  // Bytes in the little-endian word-count header and in each data word.
  localparam int unsigned HEADER_BYTES = 4;
  localparam int unsigned WORD_BYTES   = 4;

  // Status outputs that are a pure function of the FSM state.
  typedef struct packed {
    logic byteReady;
    logic cpuRst;
    logic done;
    logic error;
  } statusFlags_t;

  // Flag values to be registered alongside a transition into 'state'.
  function automatic statusFlags_t flagsFor(input loaderState_t state);
    statusFlags_t flags;
    flags.byteReady = (state == HEADER) || (state == DATA) || (state == CHECK);
    flags.cpuRst    = (state != DONE);
    flags.done      = (state == DONE);
    flags.error     = (state == ERROR);
    return flags;
  endfunction

endpackage

// File: rtl/program_loader_ByteAssembler32b.sv
// ByteAssembler32b
//   Collects bytes into a 32-bit little-endian word. The first byte of a word
//   lands in bits [7:0]. wordDone pulses in the cycle the final byte is
//   accepted, with the complete word presented on 'word' in that same cycle.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clear          drop any partial word (start of a new load)
//   byteStrobe     a byte is accepted this cycle
//   byteIn         the accepted byte
//   lastIndex      index of the final byte of the current unit (length - 1)
//   word           assembled word including the byte accepted this cycle
//   wordDone       final byte of the unit accepted this cycle
module ByteAssembler32b
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byteStrobe,
  input  logic [7:0]  byteIn,
  input  logic [1:0]  lastIndex,
  output logic [31:0] word,
  output logic        wordDone
);

  logic [31:0] shiftR;
  logic [1:0]  countR;

  // Bytes shift in from the top so the earliest byte ends up least significant.
  assign word     = {byteIn, shiftR[31:8]};
  assign wordDone = byteStrobe && (countR == lastIndex);

  // Shift register and byte counter; stalls hold both untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftR <= 32'h0000_0000;
      countR <= 2'd0;
    end else if (clear) begin
      shiftR <= 32'h0000_0000;
      countR <= 2'd0;
    end else if (byteStrobe) begin
      shiftR <= {byteIn, shiftR[31:8]};
      countR <= wordDone ? 2'd0 : countR + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Loads a program image from a byte stream into a word memory while holding
//   the downstream CPU in reset. Stream: 4-byte LE word count N, then N LE
//   data words. Words are written to BASE_ADDR + 4*index.
//   Optional feature macro PROGRAM_LOADER_CHECKSUM_EN: a trailing LE checksum
//   word (XOR of all data words) is checked before releasing the CPU.
// Parameters:
//   ADDR_WIDTH     word-address width of the target memory (2^ADDR_WIDTH words)
//   BASE_ADDR      byte address of the first loaded word
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          one-cycle pulse starting a load (IDLE/DONE/ERROR only)
//   byteIn         stream byte, byteValid qualifies it, byteReady accepts it
//   memAddress     word-aligned byte address of the memory write
//   memWriteEnable memory write strobe (one cycle per word)
//   memWriteData   memory write data
//   cpuRst         active-high CPU hold, released only in DONE
//   done, error    terminal status flags
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [31:0] memAddress,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  output logic        cpuRst,
  output logic        done,
  output logic        error
);

  localparam logic [32:0]         MAX_WORDS = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] INDEX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  loaderState_t        stateR;
  statusFlags_t        flagsR;
  logic [ADDR_WIDTH:0] indexR;
  logic [ADDR_WIDTH:0] wordCountR;
  logic [ADDR_WIDTH:0] nextIndexS;
  logic [31:0]         writeAddrS;
  logic [31:0]         asmWordS;
  logic                asmDoneS;
  logic                byteFireS;
  logic                restartS;
  logic [1:0]          lastIndexS;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]         xorR;
`endif

  assign byteFireS  = byteValid && flagsR.byteReady;
  assign restartS   = start && ((stateR == IDLE) || (stateR == DONE) || (stateR == ERROR));
  assign lastIndexS = (stateR == HEADER) ? 2'(HEADER_BYTES - 1) : 2'(WORD_BYTES - 1);
  // index never exceeds N <= 2^ADDR_WIDTH, so the +1 cannot overflow.
  assign nextIndexS = indexR + INDEX_ONE;
  assign writeAddrS = BASE_ADDR + 32'({indexR, 2'b00});

  assign byteReady = flagsR.byteReady;
  assign cpuRst    = flagsR.cpuRst;
  assign done      = flagsR.done;
  assign error     = flagsR.error;

  ByteAssembler32b u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (restartS),
    .byteStrobe (byteFireS),
    .byteIn     (byteIn),
    .lastIndex  (lastIndexS),
    .word       (asmWordS),
    .wordDone   (asmDoneS)
  );

  // Load FSM; status flags and memory port are registered with each transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR         <= IDLE;
      flagsR         <= flagsFor(IDLE);
      indexR         <= {(ADDR_WIDTH + 1){1'b0}};
      wordCountR     <= {(ADDR_WIDTH + 1){1'b0}};
      memAddress     <= 32'h0000_0000;
      memWriteData   <= 32'h0000_0000;
      memWriteEnable <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xorR           <= 32'h0000_0000;
`endif
    end else begin
      case (stateR)
        IDLE, DONE, ERROR: begin
          if (start) begin
            stateR <= HEADER;
            flagsR <= flagsFor(HEADER);
            indexR <= {(ADDR_WIDTH + 1){1'b0}};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorR   <= 32'h0000_0000;
`endif
          end
        end
        HEADER: begin
          if (asmDoneS) begin
            wordCountR <= asmWordS[ADDR_WIDTH:0];
            if (asmWordS == 32'h0000_0000) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              // An empty image still carries a checksum word, expected zero.
              stateR <= CHECK;
              flagsR <= flagsFor(CHECK);
`else
              stateR <= DONE;
              flagsR <= flagsFor(DONE);
`endif
            end else if ({1'b0, asmWordS} > MAX_WORDS) begin
              stateR <= ERROR;
              flagsR <= flagsFor(ERROR);
            end else begin
              stateR <= DATA;
              flagsR <= flagsFor(DATA);
            end
          end
        end
        DATA: begin
          if (asmDoneS) begin
            stateR         <= WRITE;
            flagsR         <= flagsFor(WRITE);
            memWriteEnable <= 1'b1;
            memWriteData   <= asmWordS;
            memAddress     <= writeAddrS;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorR           <= xorR ^ asmWordS;
`endif
          end
        end
        WRITE: begin
          memWriteEnable <= 1'b0;
          indexR         <= nextIndexS;
          if (nextIndexS < wordCountR) begin
            stateR <= DATA;
            flagsR <= flagsFor(DATA);
          end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            stateR <= CHECK;
            flagsR <= flagsFor(CHECK);
`else
            stateR <= DONE;
            flagsR <= flagsFor(DONE);
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (asmDoneS) begin
            if (asmWordS == xorR) begin
              stateR <= DONE;
              flagsR <= flagsFor(DONE);
            end else begin
              stateR <= ERROR;
              flagsR <= flagsFor(ERROR);
            end
          end
        end
`endif
        default: begin
          stateR         <= IDLE;
          flagsR         <= flagsFor(IDLE);
          memWriteEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;

  logic        byteReady, memWriteEnable, cpuRst, done, error;
  logic [31:0] memAddress, memWriteData;
  logic        sByteReady, sMemWriteEnable, sCpuRst, sDone, sError;
  logic [31:0] sMemAddress, sMemWriteData;

  int checks = 0;
  int passes = 0;
  int writeCount = 0;
  int smallWriteCount = 0;
  logic [63:0] expQ[$];

  localparam logic [68:0] RESET_VIEW = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
  logic [68:0] view;
  assign view = {byteReady, memWriteEnable, memAddress, memWriteData, cpuRst, done, error};

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .cpuRst(cpuRst), .done(done), .error(error)
  );

  program_loader #(.ADDR_WIDTH(2)) dutSmall (
    .clk(clk), .rst(rst), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(sByteReady), .memAddress(sMemAddress), .memWriteEnable(sMemWriteEnable),
    .memWriteData(sMemWriteData), .cpuRst(sCpuRst), .done(sDone), .error(sError)
  );

  // Scoreboard: every write of the main instance is matched against the queue.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (memWriteEnable === 1'b1) begin
      writeCount++;
      checks++;
      if (expQ.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", memAddress, memWriteData);
      end else begin
        e = expQ.pop_front();
        if ({memAddress, memWriteData} !== e)
          $display("FAIL write_seq: got addr=%h data=%h, required addr=%h data=%h",
                   memAddress, memWriteData, e[63:32], e[31:0]);
        else passes++;
      end
      checks++;
      if (byteReady !== 1'b0) $display("FAIL write_ready: byteReady=%b in WRITE, required 0", byteReady);
      else passes++;
    end
    if (sMemWriteEnable === 1'b1) smallWriteCount++;
  end

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int waitCycles = 0;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) begin
        byteValid = 1'b0;
        @(negedge clk);
      end
    end
    byteIn = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (byteReady !== 1'b1) begin
      checks++;
      $display("FAIL byte_accept: byteReady=%b after %0d cycles, required 1", byteReady, waitCycles);
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], gaps);
  endtask

  task automatic waitTerminal();
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1 && error !== 1'b1) begin
      checks++;
      $display("FAIL terminal_timeout: done=%b error=%b after %0d cycles, required a terminal state", done, error, n);
    end
  endtask

  task automatic sendImage(input bit gaps);
    expQ.push_back({32'h0000_0000, 32'h1234_5678});
    expQ.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    sendWord(32'd2, gaps);
    sendWord(32'h1234_5678, gaps);
    sendWord(32'hDEAD_BEEF, gaps);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (view !== RESET_VIEW) $display("FAIL reset_outputs: got %h, required %h", view, RESET_VIEW);
    else passes++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (view !== RESET_VIEW) $display("FAIL idle_outputs: got %h, required %h", view, RESET_VIEW);
    else passes++;
  endtask

  task automatic test_error();
    pulseStart();
    checks++;
    if ({sByteReady, sCpuRst, sDone} !== 3'b110)
      $display("FAIL err_header: ready/cpuRst/done=%b, required 110", {sByteReady, sCpuRst, sDone});
    else passes++;
    sendWord(32'd5, 1'b0);
    checks++;
    if ({sError, sDone, sCpuRst, sByteReady} !== 4'b1010)
      $display("FAIL err_state: error/done/cpuRst/ready=%b, required 1010", {sError, sDone, sCpuRst, sByteReady});
    else passes++;
    checks++;
    if (smallWriteCount != 0 || sMemAddress !== 32'h0 || sMemWriteData !== 32'h0)
      $display("FAIL err_nowrite: writes=%0d addr=%h data=%h, required 0/0/0", smallWriteCount, sMemAddress, sMemWriteData);
    else passes++;
    pulseStart();
    checks++;
    if ({sError, sByteReady, sCpuRst} !== 3'b011)
      $display("FAIL err_restart: error/ready/cpuRst=%b, required 011", {sError, sByteReady, sCpuRst});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w0 = writeCount;
    pulseStart();
    checks++;
    if ({byteReady, cpuRst, done} !== 3'b110)
      $display("FAIL basic_header: ready/cpuRst/done=%b, required 110", {byteReady, cpuRst, done});
    else passes++;
    sendImage(1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendWord(32'hCC99_E897, 1'b0);
`endif
    waitTerminal();
    checks++;
    if ({done, error, cpuRst, byteReady} !== 4'b1000)
      $display("FAIL basic_done: done/error/cpuRst/ready=%b, required 1000", {done, error, cpuRst, byteReady});
    else passes++;
    checks++;
    if (writeCount - w0 != 2 || expQ.size() != 0)
      $display("FAIL basic_count: writes=%0d pending=%0d, required 2/0", writeCount - w0, expQ.size());
    else passes++;
    checks++;
    if ({memWriteEnable, memAddress, memWriteData} !== {1'b0, 32'h4, 32'hDEAD_BEEF})
      $display("FAIL basic_hold: we=%b addr=%h data=%h, required 0/00000004/deadbeef", memWriteEnable, memAddress, memWriteData);
    else passes++;
  endtask

  task automatic test_zero();
    int w0 = writeCount;
    pulseStart();
    for (int i = 0; i < 3; i++) sendByte(8'h00, 1'b0);
    checks++;
    if (done !== 1'b0) $display("FAIL zero_early: done=%b after 3 bytes, required 0", done);
    else passes++;
    sendByte(8'h00, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checks++;
    if ({byteReady, done} !== 2'b10) $display("FAIL zero_check: ready/done=%b, required 10", {byteReady, done});
    else passes++;
    sendWord(32'h0, 1'b0);
`endif
    checks++;
    if ({done, cpuRst, error} !== 3'b100)
      $display("FAIL zero_done: done/cpuRst/error=%b, required 100", {done, cpuRst, error});
    else passes++;
    checks++;
    if (writeCount != w0) $display("FAIL zero_nowrite: writes=%0d, required 0", writeCount - w0);
    else passes++;
  endtask

  task automatic test_random();
    int w0 = writeCount;
    pulseStart();
    sendImage(1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendWord(32'hCC99_E897, 1'b1);
`endif
    waitTerminal();
    checks++;
    if ({done, cpuRst} !== 2'b10) $display("FAIL random_done: done/cpuRst=%b, required 10", {done, cpuRst});
    else passes++;
    checks++;
    if (writeCount - w0 != 2 || expQ.size() != 0)
      $display("FAIL random_count: writes=%0d pending=%0d, required 2/0", writeCount - w0, expQ.size());
    else passes++;
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    pulseStart();
    sendImage(1'b0);
    sendWord(32'h0000_0000, 1'b0);
    waitTerminal();
    checks++;
    if ({error, done, cpuRst} !== 3'b101)
      $display("FAIL csum_bad: error/done/cpuRst=%b, required 101", {error, done, cpuRst});
    else passes++;
  endtask
`endif

  task automatic test_midreset();
    int w0 = writeCount;
    pulseStart();
    sendWord(32'd2, 1'b0);
    sendByte(8'h78, 1'b0);
    sendByte(8'h56, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (view !== RESET_VIEW) $display("FAIL midreset_outputs: got %h, required %h", view, RESET_VIEW);
    else passes++;
    byteIn = 8'h34;
    byteValid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    byteValid = 1'b0;
    checks++;
    if (writeCount != w0 || byteReady !== 1'b0 || cpuRst !== 1'b1)
      $display("FAIL midreset_nowrite: writes=%0d ready=%b cpuRst=%b, required 0/0/1", writeCount - w0, byteReady, cpuRst);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_error();
    test_basic();
    test_zero();
    test_random();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_midreset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
